cache_fill_ctrl: RTL and testbench

- Controls one 2-way set-associative cache instance: 64 sets, 16-byte blocks (8 x 16-bit words), 16-bit byte address.
- Sequences the per-way metadata arrays and the data array.
- Detects hit/miss, keeps the LRU state, and on a miss fetches the block word by word from pipelined main memory.
- One instance sits between each pipeline stage that has a cache (I-side and D-side) and shared memory.

---
 rtl/cache_fill_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - 2-way set-associative cache controller: hit/miss, LRU upkeep, word-by-word block fill
module cache_fill_ctrl #(
  parameter int NUM_SETS = 64,
  parameter int WORDS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [15:0]         addr,
  input  logic [7:0]          meta0,
  input  logic [7:0]          meta1,
  input  logic                mem_data_valid,
  output logic [NUM_SETS-1:0] set_enable,
  output logic [7:0]          meta_din,
  output logic                meta_wr0,
  output logic                meta_wr1,
  output logic                data_wr,
  output logic                data_way,
  output logic [WORDS-1:0]    word_sel,
  output logic                mem_req,
  output logic [15:0]         mem_addr,
  output logic                hit,
  output logic                hit_way,
  output logic                stall
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int WW = $clog2(WORDS);
  localparam int TW = 16 - IW - WW - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HIT_LRU = 3'd1;
  localparam logic [2:0] S_FILL    = 3'd2;
  localparam logic [2:0] S_META_WR = 3'd3;
  localparam logic [2:0] S_LRU_WR  = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] lat_tag;
  logic [IW-1:0] lat_idx;
  logic [7:0]    lat_meta0;
  logic          lat_hit_way;
  logic          victim;
  logic [WW-1:0] issue_cnt;
  logic [WW-1:0] ret_cnt;
  logic          issue_done;

  logic [TW-1:0] addr_tag;
  logic [IW-1:0] addr_idx;
  logic [IW-1:0] sel_idx;
  logic          tag_match0, tag_match1, any_hit, miss, hw, lru_change, victim_sel;
  logic          bits_unused;

  assign addr_tag    = addr[15:16-TW];
  assign addr_idx    = addr[15-TW -: IW];
  assign tag_match0  = meta0[7] & (meta0[5:0] == addr_tag);
  assign tag_match1  = meta1[7] & (meta1[5:0] == addr_tag);
  assign any_hit     = req & (tag_match0 | tag_match1);
  assign miss        = req & ~(tag_match0 | tag_match1);
  assign hw          = ~tag_match0;
  // meta0[6]=1 means way1 is LRU; a hit only costs a cycle when it flips that bit
  assign lru_change  = hw ? meta0[6] : ~meta0[6];
  assign victim_sel  = ~meta0[7] ? 1'b0 : (~meta1[7] ? 1'b1 : meta0[6]);
  assign sel_idx     = (state == S_IDLE) ? addr_idx : lat_idx;
  assign bits_unused = ^{meta1[6], addr[0], lat_meta0[6]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      lat_tag     <= '0;
      lat_idx     <= '0;
      lat_meta0   <= '0;
      lat_hit_way <= 1'b0;
      victim      <= 1'b0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      issue_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_hit && lru_change) begin
            lat_idx     <= addr_idx;
            lat_meta0   <= meta0;
            lat_hit_way <= hw;
            state       <= S_HIT_LRU;
          end else if (miss) begin
            lat_tag   <= addr_tag;
            lat_idx   <= addr_idx;
            lat_meta0 <= meta0;
            victim    <= victim_sel;
            state     <= S_FILL;
          end
        end
        S_HIT_LRU: state <= S_IDLE;
        S_FILL: begin
          if (!issue_done) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == WW'(WORDS - 1)) issue_done <= 1'b1;
          end
          if (mem_data_valid) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == WW'(WORDS - 1)) begin
              issue_cnt  <= '0;
              issue_done <= 1'b0;
              state      <= S_META_WR;
            end
          end
        end
        S_META_WR: state <= victim ? S_LRU_WR : S_IDLE;
        S_LRU_WR:  state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    set_enable = NUM_SETS'(1) << sel_idx;
    meta_din   = '0;
    meta_wr0   = 1'b0;
    meta_wr1   = 1'b0;
    data_wr    = 1'b0;
    data_way   = 1'b0;
    word_sel   = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    hit        = 1'b0;
    hit_way    = 1'b0;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        hit     = any_hit;
        hit_way = any_hit & hw;
        stall   = miss;
      end
      S_HIT_LRU: begin
        stall    = 1'b1;
        meta_wr0 = 1'b1;
        meta_din = {lat_meta0[7], ~lat_hit_way, lat_meta0[5:0]};
      end
      S_FILL: begin
        stall   = 1'b1;
        mem_req = ~issue_done;
        if (!issue_done) mem_addr = {lat_tag, lat_idx, issue_cnt, 1'b0};
        data_wr = mem_data_valid;
        if (mem_data_valid) begin
          data_way = victim;
          word_sel = WORDS'(1) << ret_cnt;
        end
      end
      S_META_WR: begin
        stall    = 1'b1;
        meta_wr0 = ~victim;
        meta_wr1 = victim;
        meta_din = {1'b1, ~victim, lat_tag};
      end
      S_LRU_WR: begin
        stall    = 1'b1;
        meta_wr0 = 1'b1;
        meta_din = {lat_meta0[7], 1'b0, lat_meta0[5:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - directed bench for cache_fill_ctrl: idle lookup table plus fill, LRU and reset sequences
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, mem_data_valid;
  logic [15:0] addr;
  logic [7:0]  meta0, meta1;
  logic [63:0] set_enable;
  logic [7:0]  meta_din, word_sel;
  logic        meta_wr0, meta_wr1, data_wr, data_way, mem_req, hit, hit_way, stall;
  logic [15:0] mem_addr;

  int total = 0;
  int bad   = 0;

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .meta0(meta0), .meta1(meta1),
    .mem_data_valid(mem_data_valid), .set_enable(set_enable), .meta_din(meta_din),
    .meta_wr0(meta_wr0), .meta_wr1(meta_wr1), .data_wr(data_wr), .data_way(data_way),
    .word_sel(word_sel), .mem_req(mem_req), .mem_addr(mem_addr), .hit(hit),
    .hit_way(hit_way), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss on a, fill with returns every gap cycles, then check metadata writes and the retry hit.
  task automatic run_miss(input logic [15:0] a, input logic [7:0] m0, input logic [7:0] m1,
                          input int gap, input logic exp_way, input logic [7:0] exp_din,
                          input logic [7:0] exp_lru_din, input logic [7:0] post_m0,
                          input logic [7:0] post_m1, input logic exp_hit_way);
    int issued, written, pending, addr_err, order_err, ctl_err, cyc;
    logic [15:0] base;
    issued = 0; written = 0; pending = 0; addr_err = 0; order_err = 0; ctl_err = 0; cyc = 0;
    base = {a[15:4], 4'h0};
    req = 1'b1; addr = a; meta0 = m0; meta1 = m1; mem_data_valid = 1'b0;
    #1;
    chk("miss_stall", stall, 1);
    chk("miss_hit", hit, 0);
    tick();
    addr = 16'hABCD;
    meta0 = 8'h5A;
    meta1 = 8'hA5;
    while (written < 8 && cyc < 200) begin
      mem_data_valid = (pending > 0) && (cyc % gap == 0);
      #1;
      if (mem_req === 1'b1) begin
        if (mem_addr !== base + 16'(2 * issued)) addr_err++;
        issued++;
      end
      if (data_wr !== mem_data_valid || stall !== 1'b1) ctl_err++;
      if (data_wr === 1'b1) begin
        if (word_sel !== 8'(1 << written) || data_way !== exp_way) order_err++;
        written++;
      end
      if (mem_data_valid) pending--;
      if (mem_req === 1'b1) pending++;
      cyc++;
      tick();
    end
    mem_data_valid = 1'b1;
    #1;
    chk("fill_words", written, 8);
    chk("fill_issued", issued, 8);
    chk("fill_addr_errs", addr_err, 0);
    chk("fill_order_errs", order_err, 0);
    chk("fill_ctl_errs", ctl_err, 0);
    chk("metawr_wr0", meta_wr0, !exp_way);
    chk("metawr_wr1", meta_wr1, exp_way);
    chk("metawr_din", meta_din, exp_din);
    chk("metawr_no_data", {data_wr, mem_req, stall}, 3'b001);
    tick();
    mem_data_valid = 1'b0;
    if (exp_way) begin
      #1;
      chk("lruwr_wr", {meta_wr0, meta_wr1, stall}, 3'b101);
      chk("lruwr_din", meta_din, exp_lru_din);
      tick();
    end
    addr = a; meta0 = post_m0; meta1 = post_m1; req = 1'b1;
    #1;
    chk("retry_hit", hit, 1);
    chk("retry_way", hit_way, exp_hit_way);
    chk("retry_stall", {stall, meta_wr0, meta_wr1}, 3'b000);
    req = 1'b0;
    tick();
  endtask

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic [7:0]  m0;
    logic [7:0]  m1;
    logic        e_hit;
    logic        e_way;
    logic        e_stall;
    int          e_idx;
  } vec_t;

  vec_t vecs[9];
  int   n;

  initial begin
    vecs[0] = '{1'b0, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 35};
    vecs[1] = '{1'b1, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 35};
    vecs[2] = '{1'b1, 16'h1234, 8'hC4, 8'h00, 1'b1, 1'b0, 1'b0, 35};
    vecs[3] = '{1'b1, 16'h1634, 8'hC4, 8'h85, 1'b1, 1'b1, 1'b0, 35};
    vecs[4] = '{1'b1, 16'h1234, 8'h84, 8'h84, 1'b1, 1'b0, 1'b0, 35};
    vecs[5] = '{1'b1, 16'h1234, 8'h04, 8'h04, 1'b0, 1'b0, 1'b1, 35};
    vecs[6] = '{1'b1, 16'hFFFE, 8'hBF, 8'h00, 1'b1, 1'b0, 1'b0, 63};
    vecs[7] = '{1'b1, 16'h0000, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 0};
    vecs[8] = '{1'b1, 16'h0400, 8'h80, 8'h81, 1'b1, 1'b1, 1'b0, 0};

    rst = 1'b0; req = 1'b0; addr = 16'h1234; meta0 = 8'h00; meta1 = 8'h00; mem_data_valid = 1'b0;
    repeat (2) tick();
    chk("rst_status", {hit, hit_way, stall, mem_req}, 4'b0000);
    chk("rst_writes", {meta_wr0, meta_wr1, data_wr, data_way}, 4'b0000);
    chk("rst_buses", {meta_din, word_sel, mem_addr}, 32'h0);
    chk("rst_set_enable", set_enable, 64'd1 << 35);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      req = vecs[i].req; addr = vecs[i].addr; meta0 = vecs[i].m0; meta1 = vecs[i].m1;
      #1;
      chk($sformatf("vec%0d_hit", i), hit, vecs[i].e_hit);
      chk($sformatf("vec%0d_way", i), hit_way, vecs[i].e_way);
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("vec%0d_set", i), set_enable, 64'd1 << vecs[i].e_idx);
      chk($sformatf("vec%0d_quiet", i), {meta_wr0, meta_wr1, data_wr, mem_req}, 4'b0000);
      req = 1'b0;
      tick();
    end

    run_miss(16'h1234, 8'h00, 8'h00, 1, 1'b0, 8'hC4, 8'h00, 8'hC4, 8'h00, 1'b0);
    run_miss(16'h1634, 8'hC4, 8'h00, 1, 1'b1, 8'h85, 8'h84, 8'h84, 8'h85, 1'b1);

    req = 1'b1; addr = 16'h1234; meta0 = 8'h84; meta1 = 8'h85;
    #1;
    chk("lruhit_idle", {hit, hit_way, stall, meta_wr0}, 4'b1000);
    tick();
    chk("lruhit_cycle", {stall, meta_wr0, meta_wr1, hit}, 4'b1100);
    chk("lruhit_din", meta_din, 8'hC4);
    tick();
    meta0 = 8'hC4;
    #1;
    chk("rehit_first", {hit, stall, meta_wr0}, 3'b100);
    tick();
    chk("rehit_no_write", {hit, stall, meta_wr0}, 3'b100);
    req = 1'b0;
    tick();

    run_miss(16'h1A34, 8'hC4, 8'h85, 3, 1'b1, 8'h86, 8'h84, 8'h84, 8'h86, 1'b1);
    run_miss(16'h1E34, 8'h84, 8'h86, 2, 1'b0, 8'hC7, 8'h00, 8'hC7, 8'h86, 1'b0);

    req = 1'b1; addr = 16'h2040; meta0 = 8'h00; meta1 = 8'h00;
    tick();
    n = 0;
    for (int k = 0; k < 6; k++) begin
      mem_data_valid = (k >= 1 && k <= 4);
      #1;
      if (data_wr === 1'b1) n++;
      tick();
    end
    chk("rstfill_words_before", n, 4);
    rst = 1'b0; req = 1'b0; mem_data_valid = 1'b1;
    #1;
    chk("rstfill_status", {stall, hit, mem_req, data_wr, meta_wr0, meta_wr1}, 6'b0);
    chk("rstfill_buses", {word_sel, mem_addr, meta_din}, 32'h0);
    tick();
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      mem_data_valid = 1'b1;
      #1;
      if (data_wr === 1'b1 || mem_req === 1'b1 || stall === 1'b1) n++;
      tick();
    end
    mem_data_valid = 1'b0;
    chk("rstfill_stale_dropped", n, 0);

    run_miss(16'h2040, 8'h00, 8'h00, 1, 1'b0, 8'hC8, 8'h00, 8'hC8, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
